// File: rtl/systolic_tile_controller.sv
// ============================================================================
// Module   : systolic_tile_controller
// Purpose  : FSM sequencing clear/load/drain/readout for an NxN systolic array
//            with K tiling; STC_PERF_CNT_EN enables the busy/stall counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module systolic_tile_controller #(
    parameter int ARRAY_SIZE  = 32,
    parameter int MAC_LATENCY = 2,
    parameter int MAX_K_TILES = 16,
    parameter int N_WIDTH     = $clog2(ARRAY_SIZE + 1),
    parameter int CNT_WIDTH   = $clog2(3 * ARRAY_SIZE + MAC_LATENCY),
    parameter int TILE_WIDTH  = $clog2(MAX_K_TILES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [N_WIDTH-1:0]    cfg_n_active_i,
    input  logic [TILE_WIDTH-1:0] cfg_k_tiles_i,
    input  logic                  cfg_acc_keep_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aborted_o,
    output logic                  pe_en_o,
    output logic                  pe_clear_acc_o,
    output logic                  skew_load_en_o,
    output logic                  skew_flush_o,
    output logic [TILE_WIDTH-1:0] tile_idx_o,
    output logic [CNT_WIDTH-1:0]  cycle_count_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
    output logic [N_WIDTH-1:0]    out_row_o,
    output logic [31:0]           perf_busy_cycles_o,
    output logic [31:0]           perf_stall_cycles_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAIN = 3'd3,
        S_READ  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                state_q;
    logic [N_WIDTH-1:0]    n_q;
    logic [TILE_WIDTH-1:0] k_q;
    logic [TILE_WIDTH-1:0] tile_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [N_WIDTH-1:0]    row_q;
    logic                  aborted_q;

    logic [N_WIDTH-1:0]    w_n_cfg;
    logic [TILE_WIDTH-1:0] w_k_cfg;
    logic [CNT_WIDTH-1:0]  w_drain_last;
    logic                  w_load_last;
    logic                  w_drain_done;
    logic                  w_row_last;
    logic                  w_more_tiles;
    logic                  w_start_ok;

    assign w_n_cfg = (cfg_n_active_i == '0 || cfg_n_active_i > N_WIDTH'(ARRAY_SIZE))
                   ? N_WIDTH'(ARRAY_SIZE) : cfg_n_active_i;
    assign w_k_cfg = (cfg_k_tiles_i == '0) ? TILE_WIDTH'(1)
                   : (cfg_k_tiles_i > TILE_WIDTH'(MAX_K_TILES)) ? TILE_WIDTH'(MAX_K_TILES)
                   : cfg_k_tiles_i;

    // Last drain index D-1 = 2*(n-1) + (MAC_LATENCY-1) - 1 = 2n + MAC_LATENCY - 4
    assign w_drain_last = CNT_WIDTH'({n_q, 1'b0}) + CNT_WIDTH'(MAC_LATENCY) - CNT_WIDTH'(4);
    assign w_load_last  = (cnt_q == CNT_WIDTH'(n_q) - CNT_WIDTH'(1));
    assign w_drain_done = (cnt_q == w_drain_last);
    assign w_row_last   = (row_q == n_q - N_WIDTH'(1));
    assign w_more_tiles = (tile_q < k_q - TILE_WIDTH'(1));
    assign w_start_ok   = (state_q == S_IDLE) && start_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            k_q       <= '0;
            tile_q    <= '0;
            cnt_q     <= '0;
            row_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            if (abort_i && state_q != S_IDLE) begin
                state_q   <= S_IDLE;
                tile_q    <= '0;
                cnt_q     <= '0;
                row_q     <= '0;
                aborted_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: if (start_i) begin
                        n_q     <= w_n_cfg;
                        k_q     <= w_k_cfg;
                        tile_q  <= '0;
                        cnt_q   <= '0;
                        row_q   <= '0;
                        state_q <= cfg_acc_keep_i ? S_LOAD : S_CLEAR;
                    end
                    S_CLEAR: state_q <= S_LOAD;
                    S_LOAD: if (in_valid_i) begin
                        if (w_load_last) begin
                            cnt_q <= '0;
                            // Next K chunk streams in back-to-back, accumulating in place
                            if (w_more_tiles) tile_q  <= tile_q + TILE_WIDTH'(1);
                            else              state_q <= S_DRAIN;
                        end else begin
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (w_drain_done) begin
                            cnt_q   <= '0;
                            state_q <= S_READ;
                        end else begin
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
                    end
                    S_READ: if (out_ready_i) begin
                        if (w_row_last) begin
                            row_q   <= '0;
                            state_q <= S_DONE;
                        end else begin
                            row_q <= row_q + N_WIDTH'(1);
                        end
                    end
                    S_DONE: begin
                        tile_q  <= '0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign in_ready_o     = (state_q == S_LOAD);
    assign busy_o         = (state_q == S_CLEAR) || (state_q == S_LOAD) ||
                            (state_q == S_DRAIN) || (state_q == S_READ);
    assign done_o         = (state_q == S_DONE);
    assign aborted_o      = aborted_q;
    assign pe_en_o        = ((state_q == S_LOAD) && in_valid_i) || (state_q == S_DRAIN);
    assign skew_load_en_o = (state_q == S_LOAD) && in_valid_i;
    assign pe_clear_acc_o = (state_q == S_CLEAR);
    assign skew_flush_o   = (state_q == S_CLEAR);
    assign tile_idx_o     = tile_q;
    assign cycle_count_o  = cnt_q;
    assign out_valid_o    = (state_q == S_READ);
    assign out_last_o     = (state_q == S_READ) && w_row_last;
    assign out_row_o      = row_q;

`ifdef STC_PERF_CNT_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else if (w_start_ok) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy_o && perf_busy_q != '1)
                perf_busy_q <= perf_busy_q + 32'd1;
            if ((state_q == S_LOAD) && !in_valid_i && perf_stall_q != '1)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_busy_cycles_o  = perf_busy_q;
    assign perf_stall_cycles_o = perf_stall_q;
`else
    logic w_unused;
    assign w_unused            = w_start_ok;
    assign perf_busy_cycles_o  = '0;
    assign perf_stall_cycles_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_tile_controller.sv
// ============================================================================
// Module   : tb_systolic_tile_controller
// Purpose  : Directed-vector bench for systolic_tile_controller (N=4, MAC_LATENCY=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_systolic_tile_controller;

    localparam int AS = 4;
    localparam int ML = 2;
    localparam int MK = 16;
    localparam int NW = 3;
    localparam int CW = 4;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NW-1:0] cfg_n = '0;
    logic [TW-1:0] cfg_k = '0;
    logic          cfg_keep = 1'b0;
    logic          in_valid = 1'b1;
    logic          in_ready;
    logic          busy, done, aborted;
    logic          pe_en, pe_clr, sk_load, sk_flush;
    logic [TW-1:0] tile_idx;
    logic [CW-1:0] cyc_cnt;
    logic          out_valid, out_last;
    logic          out_ready = 1'b1;
    logic [NW-1:0] out_row;
    logic [31:0]   perf_busy, perf_stall;

    systolic_tile_controller #(
        .ARRAY_SIZE (AS),
        .MAC_LATENCY(ML),
        .MAX_K_TILES(MK)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_i            (start),
        .abort_i            (abort),
        .cfg_n_active_i     (cfg_n),
        .cfg_k_tiles_i      (cfg_k),
        .cfg_acc_keep_i     (cfg_keep),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .busy_o             (busy),
        .done_o             (done),
        .aborted_o          (aborted),
        .pe_en_o            (pe_en),
        .pe_clear_acc_o     (pe_clr),
        .skew_load_en_o     (sk_load),
        .skew_flush_o       (sk_flush),
        .tile_idx_o         (tile_idx),
        .cycle_count_o      (cyc_cnt),
        .out_valid_o        (out_valid),
        .out_ready_i        (out_ready),
        .out_last_o         (out_last),
        .out_row_o          (out_row),
        .perf_busy_cycles_o (perf_busy),
        .perf_stall_cycles_o(perf_stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Per-run stimulus windows (cycle numbers relative to the start edge)
    int iv_lo = 0, iv_hi = -1, or_lo = 0, or_hi = -1, ab_at = -1;

    logic [63:0] tr_rdy, tr_pe, tr_sl, tr_clr, tr_fl, tr_busy, tr_done, tr_abt, tr_ov, tr_ol;
    int          tr_cnt [64];
    int          tr_tile[64];
    int          tr_row [64];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int first1(input logic [63:0] v);
        for (int i = 0; i < 64; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int last1(input logic [63:0] v);
        for (int i = 63; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    task automatic run_job(input int n, input int k, input logic keep);
        int end_c;
        tr_rdy = '0; tr_pe = '0; tr_sl = '0; tr_clr = '0; tr_fl = '0;
        tr_busy = '0; tr_done = '0; tr_abt = '0; tr_ov = '0; tr_ol = '0;
        for (int i = 0; i < 64; i++) begin
            tr_cnt[i] = -1; tr_tile[i] = -1; tr_row[i] = -1;
        end
        cfg_n    = NW'(n);
        cfg_k    = TW'(k);
        cfg_keep = keep;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        end_c = -1;
        for (int c = 1; c < 64; c++) begin
            in_valid  = !(c >= iv_lo && c <= iv_hi);
            out_ready = !(c >= or_lo && c <= or_hi);
            abort     = (c == ab_at);
            #1;
            tr_rdy[c] = in_ready;  tr_pe[c] = pe_en;    tr_sl[c] = sk_load;
            tr_clr[c] = pe_clr;    tr_fl[c] = sk_flush; tr_busy[c] = busy;
            tr_done[c] = done;     tr_abt[c] = aborted; tr_ov[c] = out_valid;
            tr_ol[c]  = out_last;
            tr_cnt[c] = int'(cyc_cnt); tr_tile[c] = int'(tile_idx); tr_row[c] = int'(out_row);
            if (end_c < 0 && (done || aborted)) end_c = c;
            @(posedge clk); #1;
            if (end_c >= 0 && c >= end_c + 3) break;
        end
        abort = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        iv_lo = 0; iv_hi = -1; or_lo = 0; or_hi = -1; ab_at = -1;
        if (end_c < 0) chk("job_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",     32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_outs",     32'({done, aborted, pe_en, pe_clr, sk_load, sk_flush, out_valid, out_last}), 0);
        chk("rst_counters", 32'({tile_idx, cyc_cnt, out_row}), 0);
        chk("rst_perf",     int'(perf_busy | perf_stall), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Baseline n=4, k=1
        run_job(4, 1, 1'b0);
        chk("t1_clear_c1",    32'(tr_clr[1]), 1);
        chk("t1_flush_c1",    32'(tr_fl[1]), 1);
        chk("t1_clear_count", $countones(tr_clr), 1);
        chk("t1_load_first",  first1(tr_rdy), 2);
        chk("t1_load_last",   last1(tr_rdy), 5);
        chk("t1_cnt_c5",      tr_cnt[5], 3);
        chk("t1_drain_pe_c6", 32'(tr_pe[6] & ~tr_rdy[6]), 1);
        chk("t1_drain_cnt12", tr_cnt[12], 6);
        chk("t1_read_first",  first1(tr_ov), 13);
        chk("t1_read_last",   last1(tr_ov), 16);
        chk("t1_row_c15",     tr_row[15], 2);
        chk("t1_last_cycle",  first1(tr_ol), 16);
        chk("t1_last_count",  $countones(tr_ol), 1);
        chk("t1_done_cycle",  first1(tr_done), 17);
        chk("t1_done_count",  $countones(tr_done), 1);
        chk("t1_busy_c16",    32'(tr_busy[16]), 1);
        chk("t1_busy_c17",    32'(tr_busy[17]), 0);
`ifdef STC_PERF_CNT_EN
        chk("t1_perf_busy",   int'(perf_busy), 16);
`else
        chk("t1_perf_busy",   int'(perf_busy), 0);
`endif
        chk("t1_perf_stall",  int'(perf_stall), 0);

        // K tiling: three chunks, one clear
        run_job(4, 3, 1'b0);
        chk("t2_clear_count", $countones(tr_clr), 1);
        chk("t2_tile_c2",     tr_tile[2], 0);
        chk("t2_tile_c6",     tr_tile[6], 1);
        chk("t2_tile_c10",    tr_tile[10], 2);
        chk("t2_cnt_c6",      tr_cnt[6], 0);
        chk("t2_load_last",   last1(tr_rdy), 13);
        chk("t2_done_cycle",  first1(tr_done), 25);

        // Input starvation at c3-4
        iv_lo = 3; iv_hi = 4;
        run_job(4, 1, 1'b0);
        chk("t3_pe_c3",       32'(tr_pe[3]), 0);
        chk("t3_pe_c4",       32'(tr_pe[4]), 0);
        chk("t3_sl_c4",       32'(tr_sl[4]), 0);
        chk("t3_sl_c5",       32'(tr_sl[5]), 1);
        chk("t3_cnt_c3",      tr_cnt[3], 1);
        chk("t3_cnt_c4",      tr_cnt[4], 1);
        chk("t3_load_last",   last1(tr_rdy), 7);
        chk("t3_done_cycle",  first1(tr_done), 19);
`ifdef STC_PERF_CNT_EN
        chk("t3_perf_stall",  int'(perf_stall), 2);
        chk("t3_perf_busy",   int'(perf_busy), 18);
`else
        chk("t3_perf_stall",  int'(perf_stall), 0);
        chk("t3_perf_busy",   int'(perf_busy), 0);
`endif

        // Readout backpressure at c14-15
        or_lo = 14; or_hi = 15;
        run_job(4, 1, 1'b0);
        chk("t4_row_c14",     tr_row[14], 1);
        chk("t4_row_c15",     tr_row[15], 1);
        chk("t4_row_c16",     tr_row[16], 1);
        chk("t4_ov_c15",      32'(tr_ov[15]), 1);
        chk("t4_read_last",   last1(tr_ov), 18);
        chk("t4_done_cycle",  first1(tr_done), 19);

        // Abort during DRAIN
        ab_at = 8;
        run_job(4, 1, 1'b0);
        chk("t5_busy_c8",     32'(tr_busy[8]), 1);
        chk("t5_abort_cycle", first1(tr_abt), 9);
        chk("t5_abort_count", $countones(tr_abt), 1);
        chk("t5_busy_c9",     32'(tr_busy[9]), 0);
        chk("t5_no_done",     $countones(tr_done), 0);

        // Abort while idle is ignored
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t5_idle_abort",  32'(aborted), 0);
        chk("t5_idle_busy",   32'(busy), 0);

        // Accumulate-keep job skips CLEAR
        run_job(4, 1, 1'b1);
        chk("t5_keep_noclr",  $countones(tr_clr), 0);
        chk("t5_keep_load1",  first1(tr_rdy), 1);
        chk("t5_keep_done",   first1(tr_done), 16);

        // Asynchronous reset mid-job
        cfg_n = 3'd4; cfg_k = 5'd1; cfg_keep = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy",    32'(busy), 0);
        chk("rstmid_ready",   32'(in_ready), 0);
        chk("rstmid_cnt",     int'(cyc_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Small active size n=2 (D=3)
        run_job(2, 1, 1'b0);
        chk("t6_load_first",  first1(tr_rdy), 2);
        chk("t6_load_last",   last1(tr_rdy), 3);
        chk("t6_drain_cnt6",  tr_cnt[6], 2);
        chk("t6_read_first",  first1(tr_ov), 7);
        chk("t6_read_last",   last1(tr_ov), 8);
        chk("t6_out_last",    first1(tr_ol), 8);
        chk("t6_done_cycle",  first1(tr_done), 9);

        // Clamped configurations behave as n=4, k=1
        run_job(0, 1, 1'b0);
        chk("t6_n0_load_last", last1(tr_rdy), 5);
        chk("t6_n0_done",      first1(tr_done), 17);
        run_job(7, 1, 1'b0);
        chk("t6_n7_done",      first1(tr_done), 17);
        run_job(4, 0, 1'b0);
        chk("t6_k0_load_last", last1(tr_rdy), 5);
        chk("t6_k0_done",      first1(tr_done), 17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
